timegen_prog: RTL and testbench

//  Programmable CRT/LCD display timing generator. It is the successor to the fixed-parameter

---
 rtl/timegen_prog.sv | 163 ++++++++++++++++
 tb/tb_timegen_prog.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timegen_prog.sv
// Programmable display timing generator: reloadable H/V timing shadowed at the frame
// boundary, selectable sync polarity, dot enable, active-area coordinates and line/frame strobes.
module timegen_prog #(
  parameter int CW      = 12,
  parameter int H_TOTAL = 800,
  parameter int H_ADDR  = 640,
  parameter int H_SYNC  = 32,
  parameter int H_BP    = 88,
  parameter int V_TOTAL = 511,
  parameter int V_ADDR  = 480,
  parameter int V_SYNC  = 4,
  parameter int V_BP    = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          HS_POL,
  input  logic          VS_POL,
  input  logic          CFG_LOAD,
  input  logic [4*CW-1:0] CFG_H,
  input  logic [4*CW-1:0] CFG_V,
  output logic          HSYNC,
  output logic          VSYNC,
  output logic          BLANK_N,
  output logic [CW-1:0] HPOS,
  output logic [CW-1:0] VPOS,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic          LINE_ODD,
  output logic          CFG_PEND,
  output logic          CFG_ERR
);

  localparam int SW = CW + 2;

  typedef struct packed {
    logic [CW-1:0] tot;
    logic [CW-1:0] addr;
    logic [CW-1:0] sync;
    logic [CW-1:0] bp;
  } axis_t;

  localparam axis_t H_DEF = '{tot: CW'(H_TOTAL), addr: CW'(H_ADDR), sync: CW'(H_SYNC), bp: CW'(H_BP)};
  localparam axis_t V_DEF = '{tot: CW'(V_TOTAL), addr: CW'(V_ADDR), sync: CW'(V_SYNC), bp: CW'(V_BP)};

  axis_t sh_h, sh_v, st_h, st_v;
  logic [CW-1:0] h_cnt, v_cnt;

  logic          hs_r, vs_r, blank_r, v_act_r;
  logic [CW-1:0] hpos_r, vpos_r;
  logic          line_start_r, frame_start_r, line_odd_r;
  logic          cfg_pend_r, cfg_err_r;

  // Sums are widened by two bits so a hostile staged config cannot wrap the range check.
  function automatic logic axis_ok(input axis_t a);
    logic [SW-1:0] span;
    span = SW'(a.sync) + SW'(a.bp) + SW'(a.addr);
    return (a.tot >= CW'(2)) && (a.addr != '0) && (a.sync != '0) && (span <= SW'(a.tot));
  endfunction

  logic [SW-1:0] h_act_lo, h_act_hi, v_act_lo, v_act_hi;
  logic          h_last, v_last, h_zero;
  logic          h_sync_d, v_sync_d, h_act_d, v_act_d, v_first;
  logic [CW-1:0] hpos_d, vpos_d;
  logic          apply_step, stage_ok;

  always_comb begin
    h_act_lo = SW'(sh_h.sync) + SW'(sh_h.bp);
    h_act_hi = h_act_lo + SW'(sh_h.addr);
    v_act_lo = SW'(sh_v.sync) + SW'(sh_v.bp);
    v_act_hi = v_act_lo + SW'(sh_v.addr);

    h_last = (h_cnt >= sh_h.tot - CW'(1));
    v_last = (v_cnt >= sh_v.tot - CW'(1));
    h_zero = (h_cnt == '0);

    h_sync_d = (h_cnt < sh_h.sync);
    v_sync_d = (v_cnt < sh_v.sync);
    h_act_d  = (SW'(h_cnt) >= h_act_lo) && (SW'(h_cnt) < h_act_hi);
    v_act_d  = (SW'(v_cnt) >= v_act_lo) && (SW'(v_cnt) < v_act_hi);
    v_first  = (SW'(v_cnt) == v_act_lo);

    hpos_d = h_act_d ? CW'(SW'(h_cnt) - h_act_lo) : '0;
    vpos_d = v_act_d ? CW'(SW'(v_cnt) - v_act_lo) : '0;

    apply_step = CE && h_last && v_last && cfg_pend_r;
    stage_ok   = axis_ok(st_h) && axis_ok(st_v);
  end

  // Timing counters and registered decodes; every output describes the position just consumed.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      h_cnt         <= '0;
      v_cnt         <= '0;
      hs_r          <= 1'b0;
      vs_r          <= 1'b0;
      blank_r       <= 1'b0;
      v_act_r       <= 1'b0;
      hpos_r        <= '0;
      vpos_r        <= '0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      line_odd_r    <= 1'b0;
    end else if (CE) begin
      hs_r          <= h_sync_d;
      blank_r       <= h_act_d && (h_zero ? v_act_d : v_act_r);
      hpos_r        <= hpos_d;
      line_start_r  <= h_zero;
      frame_start_r <= h_zero && (v_cnt == '0);
      // Vertical decodes are latched only at the start of a line so they stay line-aligned.
      if (h_zero) begin
        vs_r       <= v_sync_d;
        v_act_r    <= v_act_d;
        vpos_r     <= vpos_d;
        line_odd_r <= v_act_d && !v_first && !line_odd_r;
      end
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= v_last ? '0 : v_cnt + CW'(1);
      end else begin
        h_cnt <= h_cnt + CW'(1);
      end
    end
  end

  // CFG_LOAD is a single-cycle strobe with no back-pressure: each cycle it is high, CFG_H/CFG_V
  // are captured regardless of CE, and it takes priority over an apply on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_h       <= H_DEF;
      sh_v       <= V_DEF;
      st_h       <= H_DEF;
      st_v       <= V_DEF;
      cfg_pend_r <= 1'b0;
      cfg_err_r  <= 1'b0;
    end else if (CFG_LOAD) begin
      st_h       <= axis_t'(CFG_H);
      st_v       <= axis_t'(CFG_V);
      cfg_pend_r <= 1'b1;
      cfg_err_r  <= 1'b0;
    end else if (apply_step) begin
      if (stage_ok) begin
        sh_h <= st_h;
        sh_v <= st_v;
      end else begin
        cfg_err_r <= 1'b1;
      end
      cfg_pend_r <= 1'b0;
    end
  end

  assign HSYNC       = hs_r ^ ~HS_POL;
  assign VSYNC       = vs_r ^ ~VS_POL;
  assign BLANK_N     = blank_r;
  assign HPOS        = hpos_r;
  assign VPOS        = vpos_r;
  assign LINE_START  = line_start_r;
  assign FRAME_START = frame_start_r;
  assign LINE_ODD    = line_odd_r;
  assign CFG_PEND    = cfg_pend_r;
  assign CFG_ERR     = cfg_err_r;

endmodule

// File: tb/tb_timegen_prog.sv
// Self-checking bench for timegen_prog: a frame-position reference model predicts every
// registered output; scenario tasks add targeted measurements of periods, widths and sequences.
module tb_timegen_prog;
  localparam int CW = 12;
  localparam int VT = 10, VA = 5, VS = 2, VB = 2;
  localparam int OW = 8 + 2 * CW;

  logic CLK = 1'b0;
  logic RST, CE, HS_POL, VS_POL, CFG_LOAD;
  logic [4*CW-1:0] CFG_H, CFG_V;
  logic HSYNC, VSYNC, BLANK_N, LINE_START, FRAME_START, LINE_ODD, CFG_PEND, CFG_ERR;
  logic [CW-1:0] HPOS, VPOS;

  timegen_prog #(.CW(CW), .V_TOTAL(VT), .V_ADDR(VA), .V_SYNC(VS), .V_BP(VB)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .HS_POL(HS_POL), .VS_POL(VS_POL),
    .CFG_LOAD(CFG_LOAD), .CFG_H(CFG_H), .CFG_V(CFG_V),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .BLANK_N(BLANK_N), .HPOS(HPOS), .VPOS(VPOS),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START), .LINE_ODD(LINE_ODD),
    .CFG_PEND(CFG_PEND), .CFG_ERR(CFG_ERR)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  int n_cmp = 0, n_bad = 0;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] got, want;

  int sh[8], st[8];    // {htot, haddr, hsync, hbp, vtot, vaddr, vsync, vbp}
  int m_p;             // position within frame the next CE step consumes
  bit m_pend, m_err;
  bit e_hs, e_vs, e_de, e_ls, e_fs, e_lo;
  int e_hpos, e_vpos;

  function automatic bit cfg_ok(input int c[8]);
    for (int a = 0; a < 8; a += 4)
      if (c[a] < 2 || c[a+1] < 1 || c[a+2] < 1 || c[a+2] + c[a+3] + c[a+1] > c[a]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [4*CW-1:0] pack4(input int t, input int a, input int s, input int b);
    return {CW'(t), CW'(a), CW'(s), CW'(b)};
  endfunction

  task automatic model_reset();
    sh = '{800, 640, 32, 88, VT, VA, VS, VB};
    st = sh;
    m_p = 0; m_pend = 0; m_err = 0;
    e_hs = 0; e_vs = 0; e_de = 0; e_ls = 0; e_fs = 0; e_lo = 0; e_hpos = 0; e_vpos = 0;
  endtask

  task automatic model_edge();
    int h, v, hlo, vlo;
    bit hact, vact, apply;
    if (CE) begin
      h = m_p % sh[0];
      v = m_p / sh[0];
      hlo = sh[2] + sh[3];
      vlo = sh[6] + sh[7];
      hact = (h >= hlo) && (h < hlo + sh[1]);
      vact = (v >= vlo) && (v < vlo + sh[5]);
      apply = (m_p == sh[0] * sh[4] - 1) && m_pend && !CFG_LOAD;
      e_hs = h < sh[2];
      e_vs = v < sh[6];
      e_de = hact && vact;
      e_hpos = hact ? h - hlo : 0;
      e_vpos = vact ? v - vlo : 0;
      e_ls = (h == 0);
      e_fs = (m_p == 0);
      e_lo = vact && ((v - vlo) % 2 == 1);
      m_p++;
      if (m_p == sh[0] * sh[4]) m_p = 0;
      if (apply) begin
        if (cfg_ok(st)) sh = st;
        else m_err = 1;
        m_pend = 0;
      end
    end
    if (CFG_LOAD) begin
      for (int k = 0; k < 4; k++) begin
        st[k]   = int'(CFG_H[(3-k)*CW +: CW]);
        st[k+4] = int'(CFG_V[(3-k)*CW +: CW]);
      end
      m_pend = 1;
      m_err = 0;
    end
  endtask

  function automatic logic [OW-1:0] exp_vec();
    return {e_hs ^ !HS_POL, e_vs ^ !VS_POL, e_de, e_ls, e_fs, e_lo, m_pend, m_err,
            CW'(e_hpos), CW'(e_vpos)};
  endfunction

  function automatic logic [OW-1:0] obs_vec();
    return {HSYNC, VSYNC, BLANK_N, LINE_START, FRAME_START, LINE_ODD, CFG_PEND, CFG_ERR, HPOS, VPOS};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge CLK);
    if (!RST) model_edge();
    #1;
    exp_q.push_back(exp_vec());
  endtask

  task automatic drive_load(input logic [4*CW-1:0] h, input logic [4*CW-1:0] v);
    CFG_H = h; CFG_V = v; CFG_LOAD = 1'b1;
    cycle();
    CFG_LOAD = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1'b1; CE = 1'b0; HS_POL = 1'b0; VS_POL = 1'b0; CFG_LOAD = 1'b0;
    CFG_H = '0; CFG_V = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    got = obs_vec(); want = exp_vec(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL reset_outputs: got %h want %h", got, want); end
    n_cmp++;
    if (HSYNC !== 1'b1 || VSYNC !== 1'b1) begin
      n_bad++; $display("FAIL reset_sync_level: got %b%b want 11", HSYNC, VSYNC);
    end
    @(negedge CLK);
    RST = 1'b0; CE = 1'b1;
  endtask

  task automatic test_defaults();
    int hs_low = 0, vs_low = 0, de = 0, max_hpos = 0, first_de = -1, fs_cnt = 0;
    for (int i = 0; i < 800 * VT; i++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL defaults pos %0d: got %h want %h", i, got, want); end
      if (HSYNC === 1'b0) hs_low++;
      if (VSYNC === 1'b0) vs_low++;
      if (BLANK_N === 1'b1) begin de++; if (first_de < 0) first_de = i; end
      if (int'(HPOS) > max_hpos) max_hpos = int'(HPOS);
      if (FRAME_START === 1'b1) fs_cnt++;
    end
    n_cmp++; if (hs_low != 32 * VT) begin n_bad++; $display("FAIL hsync_low: got %0d want %0d", hs_low, 32 * VT); end
    n_cmp++; if (vs_low != 800 * VS) begin n_bad++; $display("FAIL vsync_low: got %0d want %0d", vs_low, 800 * VS); end
    n_cmp++; if (de != 640 * VA) begin n_bad++; $display("FAIL de_count: got %0d want %0d", de, 640 * VA); end
    n_cmp++; if (first_de != 800 * (VS + VB) + 120) begin n_bad++; $display("FAIL first_de: got %0d want %0d", first_de, 800 * (VS + VB) + 120); end
    n_cmp++; if (max_hpos != 639) begin n_bad++; $display("FAIL max_hpos: got %0d want 639", max_hpos); end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL fs_count: got %0d want 1", fs_cnt); end
    cycle();
    got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want || FRAME_START !== 1'b1) begin n_bad++; $display("FAIL frame_period: got %h want %h", got, want); end
  endtask

  task automatic test_cfg_apply();
    bit seen = 0;
    int de = 0, max_hpos = 0, max_vpos = 0, first_de = -1;
    int fs_k[$];
    repeat (100) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL apply_pre: got %h want %h", got, want); end
    end
    drive_load(pack4(20, 8, 2, 4), pack4(10, 4, 1, 2));
    got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want || CFG_PEND !== 1'b1) begin n_bad++; $display("FAIL apply_pend: got %h want %h", got, want); end
    for (int i = 0; i < 9000; i++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL apply_wait step %0d: got %h want %h", i, got, want); end
      if (FRAME_START === 1'b1) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL apply_boundary: got no FRAME_START want one within 9000"); end
    for (int k = 1; k <= 400; k++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL apply_small k %0d: got %h want %h", k, got, want); end
      if (BLANK_N === 1'b1) begin de++; if (first_de < 0) first_de = k; end
      if (int'(HPOS) > max_hpos) max_hpos = int'(HPOS);
      if (int'(VPOS) > max_vpos) max_vpos = int'(VPOS);
      if (FRAME_START === 1'b1) fs_k.push_back(k);
    end
    n_cmp++; if (de != 64) begin n_bad++; $display("FAIL small_de: got %0d want 64", de); end
    n_cmp++; if (first_de != 66) begin n_bad++; $display("FAIL small_first_de: got %0d want 66", first_de); end
    n_cmp++; if (max_hpos != 7 || max_vpos != 3) begin n_bad++; $display("FAIL small_pos_max: got %0d/%0d want 7/3", max_hpos, max_vpos); end
    n_cmp++;
    if (fs_k.size() != 2 || fs_k[0] != 200 || fs_k[1] != 400) begin
      n_bad++; $display("FAIL small_frame_period: got %0d strobes want 2 at 200,400", fs_k.size());
    end
  endtask

  task automatic test_ce_toggle();
    logic [OW-1:0] prev;
    logic ce_now, prev_ls;
    int rises[$];
    bit period_ok = 1;
    prev = obs_vec(); prev_ls = LINE_START;
    for (int i = 0; i < 800; i++) begin
      ce_now = (i % 2 == 0);
      CE = ce_now;
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL ce_model clk %0d: got %h want %h", i, got, want); end
      n_cmp++;
      if (!ce_now && got !== prev) begin n_bad++; $display("FAIL ce_hold clk %0d: got %h want %h", i, got, prev); end
      if (LINE_START === 1'b1 && prev_ls === 1'b0) rises.push_back(i);
      prev = got; prev_ls = LINE_START;
    end
    CE = 1'b1;
    for (int j = 1; j < rises.size(); j++) if (rises[j] - rises[j-1] != 40) period_ok = 0;
    n_cmp++;
    if (rises.size() < 3 || !period_ok) begin
      n_bad++; $display("FAIL ce_line_period: got %0d rises ok=%0d want period 40", rises.size(), period_ok);
    end
  endtask

  task automatic test_invalid_cfg();
    bit seen;
    int de;
    drive_load(pack4(20, 8, 12, 4), pack4(10, 4, 1, 2));
    got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL bad_load: got %h want %h", got, want); end
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL bad_wait: got %h want %h", got, want); end
      if (CFG_PEND === 1'b0) begin seen = 1; break; end
    end
    n_cmp++;
    if (!seen || CFG_ERR !== 1'b1) begin n_bad++; $display("FAIL bad_reject: got pend_drop=%0d err=%b want 1 1", seen, CFG_ERR); end
    de = 0;
    repeat (200) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL bad_keep: got %h want %h", got, want); end
      if (BLANK_N === 1'b1) de++;
    end
    n_cmp++; if (de != 32) begin n_bad++; $display("FAIL bad_old_timing: got %0d want 32", de); end
    drive_load(pack4(24, 10, 3, 5), pack4(8, 3, 1, 1));
    got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want || CFG_ERR !== 1'b0 || CFG_PEND !== 1'b1) begin
      n_bad++; $display("FAIL err_clear: got %h want %h", got, want);
    end
    seen = 0;
    for (int i = 0; i < 500; i++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL good_wait: got %h want %h", got, want); end
      if (CFG_PEND === 1'b0) begin seen = 1; break; end
    end
    de = 0;
    repeat (192) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL good_run: got %h want %h", got, want); end
      if (BLANK_N === 1'b1) de++;
    end
    n_cmp++;
    if (!seen || de != 30) begin n_bad++; $display("FAIL good_timing: got pend_drop=%0d de=%0d want 1 30", seen, de); end
  endtask

  task automatic test_load_on_apply();
    int fs_k[$];
    drive_load(pack4(16, 6, 2, 3), pack4(6, 3, 1, 1));
    got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want) begin n_bad++; $display("FAIL race_first: got %h want %h", got, want); end
    for (int i = 0; i < 400; i++) begin
      if (m_p == sh[0] * sh[4] - 1) break;
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL race_wait: got %h want %h", got, want); end
    end
    drive_load(pack4(12, 4, 1, 2), pack4(5, 2, 1, 1));
    got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
    if (got !== want || CFG_PEND !== 1'b1) begin n_bad++; $display("FAIL race_pend: got %h want %h", got, want); end
    for (int k = 1; k <= 253; k++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL race_run k %0d: got %h want %h", k, got, want); end
      if (FRAME_START === 1'b1) fs_k.push_back(k);
    end
    n_cmp++;
    if (fs_k.size() != 3 || fs_k[1] - fs_k[0] != 192 || fs_k[2] - fs_k[1] != 60) begin
      n_bad++; $display("FAIL race_defer: got %0d strobes want frames of 192 then 60", fs_k.size());
    end
  endtask

  task automatic test_random();
    bit seen;
    for (int it = 0; it < 8; it++) begin
      HS_POL = 1'($urandom_range(0, 1));
      VS_POL = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 150)) begin
        CE = ($urandom_range(0, 3) != 0);
        cycle();
        got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL rand_pre it %0d: got %h want %h", it, got, want); end
      end
      CE = ($urandom_range(0, 3) != 0);
      drive_load(pack4($urandom_range(4, 20), $urandom_range(1, 8), $urandom_range(0, 4), $urandom_range(0, 4)),
                 pack4($urandom_range(3, 10), $urandom_range(1, 5), $urandom_range(0, 3), $urandom_range(0, 3)));
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL rand_load it %0d: got %h want %h", it, got, want); end
      seen = 0;
      for (int i = 0; i < 2500; i++) begin
        CE = ($urandom_range(0, 3) != 0);
        cycle();
        got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL rand_wait it %0d: got %h want %h", it, got, want); end
        if (CFG_PEND === 1'b0) begin seen = 1; break; end
      end
      n_cmp++;
      if (!seen) begin n_bad++; $display("FAIL rand_boundary it %0d: got pending want applied", it); end
      repeat (300) begin
        CE = ($urandom_range(0, 3) != 0);
        cycle();
        got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
        if (got !== want) begin n_bad++; $display("FAIL rand_run it %0d: got %h want %h", it, got, want); end
      end
    end
    CE = 1'b1; HS_POL = 1'b0; VS_POL = 1'b0;
  endtask

  task automatic test_line_odd_pol_reset();
    bit seen;
    bit odd_q[$];
    logic h0, v0;
    drive_load(pack4(10, 4, 1, 2), pack4(9, 4, 1, 2));
    void'(exp_q.pop_front());
    seen = 0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL odd_wait: got %h want %h", got, want); end
      if (FRAME_START === 1'b1 && CFG_PEND === 1'b0) begin seen = 1; break; end
    end
    for (int k = 1; k < 90; k++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL odd_run: got %h want %h", got, want); end
      if (BLANK_N === 1'b1 && HPOS == '0) odd_q.push_back(LINE_ODD);
    end
    n_cmp++;
    if (!seen || odd_q.size() != 4 || odd_q[0] != 0 || odd_q[1] != 1 || odd_q[2] != 0 || odd_q[3] != 1) begin
      n_bad++; $display("FAIL line_odd_seq: got %0d samples %p want 0,1,0,1", odd_q.size(), odd_q);
    end
    h0 = HSYNC; HS_POL = 1'b1; #1;
    n_cmp++; if (HSYNC !== ~h0) begin n_bad++; $display("FAIL hs_pol_flip: got %b want %b", HSYNC, ~h0); end
    v0 = VSYNC; VS_POL = 1'b1; #1;
    n_cmp++; if (VSYNC !== ~v0) begin n_bad++; $display("FAIL vs_pol_flip: got %b want %b", VSYNC, ~v0); end
    @(negedge CLK);
    drive_load(pack4(30, 10, 2, 2), pack4(9, 4, 1, 2));
    void'(exp_q.pop_front());
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL rst_wait: got %h want %h", got, want); end
      if (BLANK_N === 1'b1) begin seen = 1; break; end
    end
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    got = obs_vec(); want = exp_vec(); n_cmp++;
    if (!seen || got !== want || CFG_PEND !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_line: got %h want %h", got, want);
    end
    @(negedge CLK);
    RST = 1'b0;
    repeat (900) begin
      cycle();
      got = obs_vec(); want = exp_q.pop_front(); n_cmp++;
      if (got !== want) begin n_bad++; $display("FAIL post_reset: got %h want %h", got, want); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_defaults();
    test_cfg_apply();
    test_ce_toggle();
    test_invalid_cfg();
    test_load_on_apply();
    test_random();
    test_line_odd_pol_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
